// File: rtl/bxu_pkg.sv
// BXU sequencer shared definitions: opcodes, FSM states, instruction fields.
package bxu_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_IN   = 4'b1011;
   localparam logic [3:0] OP_OUT  = 4'b0011;
   localparam logic [3:0] OP_JMP  = 4'b0101;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam int OPC_LSB       = 0;
   localparam int OPC_W         = 4;
   localparam int OPND_LSB      = 4;
   localparam int OPND_W        = 12;
   localparam int OUT_SRC_D_BIT = 9;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_WAIT_RX,
      S_WAIT_TX,
      S_HALT
   } state_t;

endpackage

// File: rtl/bxu_sequencer.sv
// BXU fetch/execute controller between program ROM and UART RX/TX streams.
// Optional BXU_SEQ_STEP_EN adds a step input for single-instruction debug.
module bxu_sequencer
   import bxu_pkg::*;
#(
   parameter int DATA_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 16,
   parameter int PROG_LEN      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run_en,
`ifdef BXU_SEQ_STEP_EN
   input  logic                     step,
`endif
   output logic [ADDR_BITWIDTH-1:0] rom_addr,
   input  logic [DATA_BITWIDTH-1:0] rom_data,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [7:0]               d_reg,
   output logic                     halted,
   output logic                     ill_op
);

   localparam logic [OPND_W-1:0] LEN_OPND = OPND_W'(PROG_LEN);
   localparam logic [ADDR_BITWIDTH-1:0] PC_LAST = ADDR_BITWIDTH'(PROG_LEN - 1);

   state_t                     state;
   logic [ADDR_BITWIDTH-1:0]   pc;
   logic [DATA_BITWIDTH-1:0]   ir;

   logic [OPC_W-1:0]           opc;
   logic [OPND_W-1:0]          opnd;
   logic [OPND_W-1:0]          jmp_mod;
   logic [ADDR_BITWIDTH-1:0]   pc_inc;
   logic [7:0]                 out_byte;
   logic                       fetch_go;
   logic                       is_in;
   logic                       is_out;
   logic                       is_jmp;
   logic                       is_halt;
   logic                       is_ill;

`ifdef BXU_SEQ_STEP_EN
   assign fetch_go = run_en & step;
`else
   assign fetch_go = run_en;
`endif

   assign opc      = ir[OPC_LSB +: OPC_W];
   assign opnd     = ir[OPND_LSB +: OPND_W];
   assign jmp_mod  = opnd % LEN_OPND;
   assign pc_inc   = (pc == PC_LAST) ? '0 : pc + ADDR_BITWIDTH'(1);
   assign out_byte = opnd[OUT_SRC_D_BIT] ? d_reg : opnd[7:0];

   assign rom_addr = pc;
   assign rx_ready = (state == S_WAIT_RX);

   always_comb begin
      is_in   = 1'b0;
      is_out  = 1'b0;
      is_jmp  = 1'b0;
      is_halt = 1'b0;
      is_ill  = 1'b0;
      unique case (opc)
         OP_NOP:  ;
         OP_IN:   is_in   = 1'b1;
         OP_OUT:  is_out  = 1'b1;
         OP_JMP:  is_jmp  = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: is_ill  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         pc       <= '0;
         ir       <= '0;
         d_reg    <= 8'h00;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         halted   <= 1'b0;
         ill_op   <= 1'b0;
      end else begin
         ill_op <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (fetch_go) begin
                  ir    <= rom_data;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_in) begin
                  state <= S_WAIT_RX;
               end else if (is_out) begin
                  tx_data  <= out_byte;
                  tx_valid <= 1'b1;
                  state    <= S_WAIT_TX;
               end else if (is_jmp) begin
                  pc    <= ADDR_BITWIDTH'(jmp_mod);
                  state <= S_FETCH;
               end else if (is_halt) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  // NOP and undefined opcodes both just advance
                  ill_op <= is_ill;
                  pc     <= pc_inc;
                  state  <= S_FETCH;
               end
            end
            S_WAIT_RX: begin
               if (rx_valid) begin
                  d_reg <= rx_data;
                  pc    <= pc_inc;
                  state <= S_FETCH;
               end
            end
            S_WAIT_TX: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  pc       <= pc_inc;
                  state    <= S_FETCH;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bxu_sequencer.sv
// Directed self-checking bench for bxu_sequencer.
// Covers echo program, TX backpressure, mid-handshake reset, JMP wrap, HALT, illegal op.
module tb_bxu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_en;
`ifdef BXU_SEQ_STEP_EN
   logic        step;
`endif
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  d_reg;
   logic        halted;
   logic        ill_op;

   logic [15:0] rom [4];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign rom_data = (rom_addr < 16'd4) ? rom[rom_addr[1:0]] : 16'h0000;

   bxu_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .run_en   (run_en),
`ifdef BXU_SEQ_STEP_EN
      .step     (step),
`endif
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .d_reg    (d_reg),
      .halted   (halted),
      .ill_op   (ill_op)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      run_en   = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
`ifdef BXU_SEQ_STEP_EN
      step     = 1'b1;
`endif
      rom[0] = 16'h000B;
      rom[1] = 16'h2003;
      rom[2] = 16'h02C3;
      rom[3] = 16'h0203;

      tick();
      tick();
      chk("rst_pc",      32'(rom_addr), 32'h0);
      chk("rst_txv",     32'(tx_valid), 32'h0);
      chk("rst_txd",     32'(tx_data),  32'h0);
      chk("rst_rxr",     32'(rx_ready), 32'h0);
      chk("rst_d",       32'(d_reg),    32'h0);
      chk("rst_halt",    32'(halted),   32'h0);
      chk("rst_ill",     32'(ill_op),   32'h0);

      // echo program
      rst      = 1'b0;
      rx_data  = 8'h41;
      rx_valid = 1'b1;
      tx_ready = 1'b1;
      run_en   = 1'b1;
      tick();
      chk("echo_rxr_exec", 32'(rx_ready), 32'h0);
      tick();
      chk("echo_rxr_wait", 32'(rx_ready), 32'h1);
      tick();
      chk("echo_d",      32'(d_reg),    32'h41);
      chk("echo_pc1",    32'(rom_addr), 32'h1);
      chk("echo_rxr_dn", 32'(rx_ready), 32'h0);
      rx_valid = 1'b0;
      tick();
      tick();
      chk("echo_txv0",   32'(tx_valid), 32'h1);
      chk("echo_tx0",    32'(tx_data),  32'h41);
      tick();
      chk("echo_txv0_dn", 32'(tx_valid), 32'h0);
      chk("echo_pc2",    32'(rom_addr), 32'h2);
      tick();
      tick();
      chk("echo_txv1",   32'(tx_valid), 32'h1);
      chk("echo_tx1",    32'(tx_data),  32'h2C);
      tick();
      chk("echo_pc3",    32'(rom_addr), 32'h3);
      tick();
      tick();
      chk("echo_tx2",    32'(tx_data),  32'h20);
      tick();
      chk("echo_wrap",   32'(rom_addr), 32'h0);
      chk("echo_txv_end", 32'(tx_valid), 32'h0);
      run_en = 1'b0;

      // frozen fetch must not take an offered rx byte
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      repeat (3) tick();
      chk("frz_rxr",     32'(rx_ready), 32'h0);
      chk("frz_pc",      32'(rom_addr), 32'h0);
      chk("frz_d",       32'(d_reg),    32'h41);

      // TX backpressure, run_en dropped mid-transfer
      run_en   = 1'b1;
      tx_ready = 1'b0;
      tick();
      tick();
      tick();
      chk("bp_d",        32'(d_reg),    32'h55);
      rx_valid = 1'b0;
      tick();
      tick();
      run_en = 1'b0;
      chk("bp_txv",      32'(tx_valid), 32'h1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_v",  32'(tx_valid), 32'h1);
         chk("bp_hold_d",  32'(tx_data),  32'h55);
         chk("bp_hold_pc", 32'(rom_addr), 32'h1);
      end

      // reset while waiting on TX
      rst = 1'b1;
      tick();
      chk("mrst_txv",    32'(tx_valid), 32'h0);
      chk("mrst_pc",     32'(rom_addr), 32'h0);
      chk("mrst_d",      32'(d_reg),    32'h0);
      chk("mrst_rxr",    32'(rx_ready), 32'h0);
      rst    = 1'b0;
      run_en = 1'b1;
      tick();
      tick();
      chk("mrst_fetch",  32'(rx_ready), 32'h1);

      // illegal op, JMP wrap, HALT
      rom[0] = 16'h0006;
      rom[1] = 16'h0065;
      rom[2] = 16'h0000;
      rom[3] = 16'h000F;
      rst = 1'b1;
      tick();
      tick();
      rst      = 1'b0;
      rx_data  = 8'h77;
      rx_valid = 1'b1;
      tx_ready = 1'b1;
      run_en   = 1'b1;
      tick();
      tick();
      chk("ill_pulse",   32'(ill_op),   32'h1);
      chk("ill_pc",      32'(rom_addr), 32'h1);
      chk("ill_txv",     32'(tx_valid), 32'h0);
      chk("ill_rxr",     32'(rx_ready), 32'h0);
      tick();
      chk("ill_clr",     32'(ill_op),   32'h0);
      tick();
      chk("jmp_pc",      32'(rom_addr), 32'h2);
      tick();
      tick();
      chk("nop_pc",      32'(rom_addr), 32'h3);
      tick();
      chk("pre_halt",    32'(halted),   32'h0);
      tick();
      chk("halt",        32'(halted),   32'h1);
      repeat (5) tick();
      chk("halt_pc",     32'(rom_addr), 32'h3);
      chk("halt_hold",   32'(halted),   32'h1);
      chk("halt_rxr",    32'(rx_ready), 32'h0);
      chk("halt_d",      32'(d_reg),    32'h0);
      rx_valid = 1'b0;

`ifdef BXU_SEQ_STEP_EN
      rom[0] = 16'h0000;
      rom[1] = 16'h0000;
      rst = 1'b1;
      tick();
      tick();
      rst    = 1'b0;
      step   = 1'b0;
      run_en = 1'b1;
      repeat (3) tick();
      chk("step_idle",   32'(rom_addr), 32'h0);
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (4) tick();
      chk("step_one",    32'(rom_addr), 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
